// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: serialises IC/DC line requests onto one memory port; define SEGRE_MEM_ARB_RR_EN for round-robin instead of IC-first priority
module segre_mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_rsp_valid_o,
  output logic [LINE_SIZE-1:0] ic_rsp_data_o,
  input  logic                 dc_req_i,
  input  logic                 dc_we_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  input  logic [LINE_SIZE-1:0] dc_wdata_i,
  output logic                 dc_rsp_valid_o,
  output logic [LINE_SIZE-1:0] dc_rsp_data_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LINE_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [LINE_SIZE-1:0] mem_rdata_i,
  output logic                 owner_dc_o,
  output logic                 busy_o,
  output logic                 spurious_rsp_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, we_q, spurious_q, pick_dc, any_req, start;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [LINE_SIZE-1:0] wdata_q, rdata_q;
  assign any_req = ic_req_i | dc_req_i;
  assign start   = (state_q == IDLE) & any_req;
`ifdef SEGRE_MEM_ARB_RR_EN
  logic last_q;
  assign pick_dc = dc_req_i & (~ic_req_i | ~last_q);
  // last winner, starts as DC so IC wins the first contested round
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) last_q <= 1'b1;
    else if (start) last_q <= pick_dc;
  end
`else
  assign pick_dc = ~ic_req_i;
`endif
  // FSM state register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and handshake strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ISSUE : IDLE;
      ISSUE:   state_d = mem_gnt_i ? WAIT : ISSUE;
      WAIT:    state_d = mem_rvalid_i ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
    mem_req_o      = state_q == ISSUE;
    busy_o         = state_q != IDLE;
    ic_rsp_valid_o = (state_q == RESP) & ~owner_q;
    dc_rsp_valid_o = (state_q == RESP) & owner_q;
  end
  // capture the winning request, the response line and stray responses
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (start) begin
        owner_q <= pick_dc;
        we_q    <= pick_dc & dc_we_i;
        addr_q  <= pick_dc ? dc_addr_i : ic_addr_i;
        wdata_q <= pick_dc ? dc_wdata_i : '0;
      end
      if ((state_q == WAIT) & mem_rvalid_i) rdata_q <= mem_rdata_i;
      if ((state_q != WAIT) & mem_rvalid_i) spurious_q <= 1'b1;
    end
  end
  assign ic_rsp_data_o  = rdata_q;
  assign dc_rsp_data_o  = rdata_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign owner_dc_o     = owner_q;
  assign spurious_rsp_o = spurious_q;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed and randomized checks of segre_mem_arbiter against a transaction-level model
module tb_segre_mem_arbiter;
  logic clk_i = 1'b0, rsn_i = 1'b0;
  logic ic_req_i = 0, dc_req_i = 0, dc_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] ic_addr_i = 0, dc_addr_i = 0, mem_addr_o;
  logic [127:0] dc_wdata_i = 0, mem_rdata_i = 0, ic_rsp_data_o, dc_rsp_data_o, mem_wdata_o;
  logic ic_rsp_valid_o, dc_rsp_valid_o, mem_req_o, mem_we_o, owner_dc_o, busy_o, spurious_rsp_o;
  int checks = 0, errors = 0;
  bit auto_on = 0, mwait = 0;
  int mcnt = 0;

  always #5 clk_i = ~clk_i;

  segre_mem_arbiter dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .owner_dc_o(owner_dc_o), .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] raddr();
    return $urandom() & 32'hFFFF_FFF0;
  endfunction

  function automatic logic [127:0] rline();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // transaction model: one outstanding line transfer, tracked as accepted / answered / reported
  logic m_active, m_granted, m_rsp, m_owner, m_we, m_spur, m_last;
  logic [31:0] m_addr;
  logic [127:0] m_wdata, m_data;

  function automatic logic winner_dc(input logic ic, input logic dc, input logic last);
`ifdef SEGRE_MEM_ARB_RR_EN
    return dc && (!ic || !last);
`else
    return !ic;
`endif
  endfunction

  always @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      m_active <= 0; m_granted <= 0; m_rsp <= 0; m_owner <= 0; m_we <= 0;
      m_spur <= 0; m_last <= 1; m_addr <= 0; m_wdata <= 0; m_data <= 0;
    end else begin
      if (mem_rvalid_i && !(m_active && m_granted && !m_rsp)) m_spur <= 1;
      if (!m_active) begin
        if (ic_req_i || dc_req_i) begin
          m_active <= 1; m_granted <= 0; m_rsp <= 0;
          m_owner <= winner_dc(ic_req_i, dc_req_i, m_last);
          m_last  <= winner_dc(ic_req_i, dc_req_i, m_last);
          m_addr  <= winner_dc(ic_req_i, dc_req_i, m_last) ? dc_addr_i : ic_addr_i;
          m_we    <= winner_dc(ic_req_i, dc_req_i, m_last) && dc_we_i;
          m_wdata <= winner_dc(ic_req_i, dc_req_i, m_last) ? dc_wdata_i : 128'h0;
        end
      end else if (!m_granted) m_granted <= mem_gnt_i;
      else if (!m_rsp) begin
        if (mem_rvalid_i) begin m_rsp <= 1; m_data <= mem_rdata_i; end
      end else m_active <= 0;
    end
  end

  always @(negedge clk_i) begin
    chk("busy", busy_o, m_active);
    chk("mem_req", mem_req_o, m_active && !m_granted);
    chk("mem_we", mem_we_o, m_we);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("owner", owner_dc_o, m_owner);
    chk("ic_rsp_valid", ic_rsp_valid_o, m_active && m_rsp && !m_owner);
    chk("dc_rsp_valid", dc_rsp_valid_o, m_active && m_rsp && m_owner);
    chk("ic_rsp_data", ic_rsp_data_o, m_data);
    chk("dc_rsp_data", dc_rsp_data_o, m_data);
    chk("spurious", spurious_rsp_o, m_spur);
  end

  task automatic step();
    @(negedge clk_i);
    if (auto_on) begin
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (mwait) begin
        if (mcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = rline(); mwait = 0; end
        else mcnt--;
      end else if (mem_req_o && $urandom_range(0, 2) != 0) begin
        mem_gnt_i = 1; mwait = 1; mcnt = $urandom_range(0, 3);
      end else if ($urandom_range(0, 299) == 0) mem_rvalid_i = 1;
      if (ic_req_i) begin
        if (ic_rsp_valid_o) ic_req_i = 0;
        else if ($urandom_range(0, 3) == 0) ic_addr_i = raddr();
      end else if ($urandom_range(0, 2) == 0) begin ic_req_i = 1; ic_addr_i = raddr(); end
      if (dc_req_i) begin
        if (dc_rsp_valid_o) dc_req_i = 0;
        else if ($urandom_range(0, 3) == 0) begin dc_addr_i = raddr(); dc_wdata_i = rline(); dc_we_i = ~dc_we_i; end
      end else if ($urandom_range(0, 2) == 0) begin
        dc_req_i = 1; dc_we_i = 1'($urandom_range(0, 1)); dc_addr_i = raddr(); dc_wdata_i = rline();
      end
    end
  endtask

  task automatic serve(input logic [127:0] d);
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = d;
    step();
    mem_rvalid_i = 0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_spurious", spurious_rsp_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rsn_i = 1;
    step();
    ic_req_i = 1; ic_addr_i = 32'h100;
    step();
    chk("icrd_req", mem_req_o, 1);
    chk("icrd_addr", mem_addr_o, 32'h100);
    chk("icrd_we", mem_we_o, 0);
    serve({4{32'hA5A5_A5A5}});
    chk("icrd_valid", ic_rsp_valid_o, 1);
    chk("icrd_data", ic_rsp_data_o, {4{32'hA5A5_A5A5}});
    chk("icrd_dcvalid", dc_rsp_valid_o, 0);
    ic_req_i = 0;
    step();
    chk("icrd_pulse", ic_rsp_valid_o, 0);
    dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h200; dc_wdata_i = 128'h1234;
    step();
    dc_addr_i = 32'hDEAD0; dc_wdata_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("dcwr_req", mem_req_o, 1);
      chk("dcwr_addr", mem_addr_o, 32'h200);
      chk("dcwr_wdata", mem_wdata_o, 128'h1234);
      chk("dcwr_we", mem_we_o, 1);
      step();
    end
    serve(128'h0);
    chk("dcwr_ack", dc_rsp_valid_o, 1);
    chk("dcwr_icvalid", ic_rsp_valid_o, 0);
    dc_req_i = 0; dc_we_i = 0;
    step();
    for (int r = 0; r < 2; r++) begin
      ic_req_i = 1; ic_addr_i = 32'h400; dc_req_i = 1; dc_addr_i = 32'h500;
      step();
      chk("both_first_owner", owner_dc_o, 0);
      chk("both_first_addr", mem_addr_o, 32'h400);
      serve(128'h11);
      chk("both_ic_valid", ic_rsp_valid_o, 1);
      ic_req_i = 0;
      step();
      step();
      chk("both_second_owner", owner_dc_o, 1);
      chk("both_second_addr", mem_addr_o, 32'h500);
      serve(128'h22);
      chk("both_dc_valid", dc_rsp_valid_o, 1);
      chk("both_dc_data", dc_rsp_data_o, 128'h22);
      dc_req_i = 0;
      step();
    end
    mem_rvalid_i = 1;
    step();
    mem_rvalid_i = 0;
    chk("spur_set", spurious_rsp_o, 1);
    chk("spur_busy", busy_o, 0);
    chk("spur_ic", ic_rsp_valid_o, 0);
    chk("spur_dc", dc_rsp_valid_o, 0);
    step();
    chk("spur_sticky", spurious_rsp_o, 1);
    ic_req_i = 1; ic_addr_i = 32'h300;
    step();
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    #1 rsn_i = 0;
    #1;
    chk("rstw_busy", busy_o, 0);
    chk("rstw_req", mem_req_o, 0);
    chk("rstw_spur", spurious_rsp_o, 0);
    chk("rstw_addr", mem_addr_o, 0);
    ic_req_i = 0;
    step();
    step();
    chk("rstw_norsp", ic_rsp_valid_o, 0);
    rsn_i = 1;
    step();
    ic_req_i = 1; ic_addr_i = 32'h300;
    step();
    chk("rstw_new_req", mem_req_o, 1);
    chk("rstw_new_addr", mem_addr_o, 32'h300);
    serve(128'h3333);
    chk("rstw_new_valid", ic_rsp_valid_o, 1);
    chk("rstw_new_data", ic_rsp_data_o, 128'h3333);
    ic_req_i = 0;
    step();
    ic_req_i = 1; ic_addr_i = 32'h600;
    step();
    serve(128'h66);
    chk("b2b_first", ic_rsp_valid_o, 1);
    ic_req_i = 0;
    step();
    ic_req_i = 1; ic_addr_i = 32'h700;
    step();
    chk("b2b_req", mem_req_o, 1);
    chk("b2b_addr", mem_addr_o, 32'h700);
    serve(128'h77);
    chk("b2b_data", ic_rsp_data_o, 128'h77);
    ic_req_i = 0;
    step();
    auto_on = 1;
    repeat (4000) step();
    auto_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
